// File: rtl/udatapath_pkg.sv
// udatapath_pkg: shared constants for the ARC micro-datapath.
// Holds the ALU operation encodings, default PC/IR register indices,
// IR field bit positions and the PSR flag record.
package udatapath_pkg;

  // ALU operation encodings (codes 0..3 update the PSR)
  localparam logic [3:0] ALU_ANDCC    = 4'd0;
  localparam logic [3:0] ALU_ORCC     = 4'd1;
  localparam logic [3:0] ALU_NORCC    = 4'd2;
  localparam logic [3:0] ALU_ADDCC    = 4'd3;
  localparam logic [3:0] ALU_SRL      = 4'd4;
  localparam logic [3:0] ALU_AND      = 4'd5;
  localparam logic [3:0] ALU_OR       = 4'd6;
  localparam logic [3:0] ALU_NOR      = 4'd7;
  localparam logic [3:0] ALU_ADD      = 4'd8;
  localparam logic [3:0] ALU_LSHIFT2  = 4'd9;
  localparam logic [3:0] ALU_LSHIFT10 = 4'd10;
  localparam logic [3:0] ALU_SIMM13   = 4'd11;
  localparam logic [3:0] ALU_SEXT13   = 4'd12;
  localparam logic [3:0] ALU_INC      = 4'd13;
  localparam logic [3:0] ALU_INCPC    = 4'd14;
  localparam logic [3:0] ALU_RSHIFT5  = 4'd15;

  // Default scratchpad indices of the program counter and instruction register
  localparam int REG_PC_IDX_DEF = 32;
  localparam int REG_IR_IDX_DEF = 37;

  // ARC instruction field positions inside the IR
  localparam int IR_OP_HI  = 31;
  localparam int IR_OP_LO  = 30;
  localparam int IR_RD_HI  = 29;
  localparam int IR_RD_LO  = 25;
  localparam int IR_OP2_HI = 24;
  localparam int IR_OP2_LO = 22;
  localparam int IR_OP3_HI = 24;
  localparam int IR_OP3_LO = 19;
  localparam int IR_RS1_HI = 18;
  localparam int IR_RS1_LO = 14;
  localparam int IR_BIT13  = 13;
  localparam int IR_RS2_HI = 4;
  localparam int IR_RS2_LO = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } psr_t;

  // Only the four condition-code operations touch the PSR
  function automatic logic isCcOp(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/udatapath_alu.sv
// udatapath_alu: purely combinational ALU for the micro-datapath.
// Overflow and carry are only meaningful for ADDCC and read 0 otherwise.
module udatapath_alu
  import udatapath_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z,
  output logic          v,
  output logic          c
);

  logic [DW:0] sum;

  // Operation select plus flag generation from the selected result
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (op)
      ALU_ANDCC, ALU_AND: result = a & b;
      ALU_ORCC, ALU_OR:   result = a | b;
      ALU_NORCC, ALU_NOR: result = ~(a | b);
      ALU_ADDCC: begin
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_ADD:      result = sum[DW-1:0];
      ALU_SRL:      result = a >> b[4:0];
      ALU_LSHIFT2:  result = a << 2;
      ALU_LSHIFT10: result = a << 10;
      ALU_SIMM13:   result = {{(DW-13){1'b0}}, a[12:0]};
      ALU_SEXT13:   result = {{(DW-13){a[12]}}, a[12:0]};
      ALU_INC:      result = a + DW'(1);
      ALU_INCPC:    result = a + DW'(4);
      ALU_RSHIFT5:  result = {{5{a[DW-1]}}, a[DW-1:5]};
      default:      result = '0;
    endcase
    n = result[DW-1];
    z = (result == '0);
  end

endmodule

// File: rtl/udatapath_pipe.sv
// udatapath_pipe: two-stage ARC micro-datapath.
// Stage 1 (accept edge) resolves A/B/C selects and latches operands; stage 2
// executes on the ALU and writes bus C back at its closing edge.
// Build option UDATAPATH_FWD_EN: forward the stage-2 result into the stage-1
// operand latch; without it a read-after-write hazard costs one stall cycle.
module udatapath_pipe
  import udatapath_pkg::*;
#(
  parameter int                         DATAWIDTH_BUS   = 32,
  parameter int                         NUM_REGS        = 38,
  parameter int                         REG_PC_IDX      = REG_PC_IDX_DEF,
  parameter int                         REG_IR_IDX      = REG_IR_IDX_DEF,
  parameter logic [DATAWIDTH_BUS-1:0]   DATA_REGPC_INIT = 'h0000_0800
) (
  input  logic                         udatapath_pipe_CLOCK_50,
  input  logic                         udatapath_pipe_Reset_InLow,
  input  logic                         uinst_valid_InHigh,
  output logic                         uinst_ready_OutHigh,
  input  logic [$clog2(NUM_REGS)-1:0]  mir_a,
  input  logic [$clog2(NUM_REGS)-1:0]  mir_b,
  input  logic [$clog2(NUM_REGS)-1:0]  mir_c,
  input  logic                         mux_sel_a,
  input  logic                         mux_sel_b,
  input  logic                         mux_sel_c,
  input  logic [3:0]                   alu_op,
  input  logic                         c_write_InHigh,
  output logic                         result_valid_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]     result_data,
  output logic                         psr_n,
  output logic                         psr_z,
  output logic                         psr_v,
  output logic                         psr_c,
  output logic [1:0]                   ir_op,
  output logic [4:0]                   ir_rd,
  output logic [2:0]                   ir_op2,
  output logic [5:0]                   ir_op3,
  output logic [4:0]                   ir_rs1,
  output logic                         ir_bit13,
  output logic [4:0]                   ir_rs2
);

  localparam int DW = DATAWIDTH_BUS;
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] IR_IDX   = AW'(REG_IR_IDX);

  logic clk;
  logic rstN;
  assign clk  = udatapath_pipe_CLOCK_50;
  assign rstN = udatapath_pipe_Reset_InLow;

  logic [DW-1:0] rf [NUM_REGS];

  logic          s2ValidReg;
  logic [DW-1:0] opAReg;
  logic [DW-1:0] opBReg;
  logic [AW-1:0] cIdxReg;
  logic [3:0]    aluOpReg;
  logic          cWriteReg;
  psr_t          psrReg;

  logic [DW-1:0] irWord;
  logic [AW-1:0] aIdx, bIdx, cIdx;
  logic [DW-1:0] rdA, rdB, opANext, opBNext;
  logic [DW-1:0] aluRes;
  logic          aluN, aluZ, aluV, aluC;
  logic          s2Write, hazA, hazB, irHazard, dataStall, accept;

  // IR field decode straight off the scratchpad IR entry
  assign irWord   = rf[REG_IR_IDX];
  assign ir_op    = irWord[IR_OP_HI:IR_OP_LO];
  assign ir_rd    = irWord[IR_RD_HI:IR_RD_LO];
  assign ir_op2   = irWord[IR_OP2_HI:IR_OP2_LO];
  assign ir_op3   = irWord[IR_OP3_HI:IR_OP3_LO];
  assign ir_rs1   = irWord[IR_RS1_HI:IR_RS1_LO];
  assign ir_bit13 = irWord[IR_BIT13];
  assign ir_rs2   = irWord[IR_RS2_HI:IR_RS2_LO];

  udatapath_alu #(.DW(DW)) alu (
    .op     (aluOpReg),
    .a      (opAReg),
    .b      (opBReg),
    .result (aluRes),
    .n      (aluN),
    .z      (aluZ),
    .v      (aluV),
    .c      (aluC)
  );

  // Stage-2 writeback qualifier; r0 is never written
  assign s2Write  = s2ValidReg && cWriteReg && (cIdxReg != '0);
  assign irHazard = (mux_sel_a || mux_sel_b || mux_sel_c) && s2Write && (cIdxReg == IR_IDX);

  // Select resolution, register reads and hazard detection for stage 1
  always_comb begin
    aIdx = mux_sel_a ? AW'(ir_rs1) : mir_a;
    bIdx = mux_sel_b ? AW'(ir_rs2) : mir_b;
    cIdx = mux_sel_c ? AW'(ir_rd)  : mir_c;
    rdA  = (aIdx <= LAST_IDX) ? rf[aIdx] : '0;
    rdB  = (bIdx <= LAST_IDX) ? rf[bIdx] : '0;
    hazA = s2Write && (aIdx == cIdxReg);
    hazB = s2Write && (bIdx == cIdxReg);
`ifdef UDATAPATH_FWD_EN
    opANext   = hazA ? aluRes : rdA;
    opBNext   = hazB ? aluRes : rdB;
    dataStall = 1'b0;
`else
    opANext   = rdA;
    opBNext   = rdB;
    dataStall = hazA || hazB;
`endif
  end

  // Ready is a function of pipeline state and selects only, never of valid
  assign uinst_ready_OutHigh = !irHazard && !dataStall;
  assign accept              = uinst_valid_InHigh && uinst_ready_OutHigh;

  // Scratchpad: boot values on reset, bus-C writeback at the end of stage 2
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= (i == REG_PC_IDX) ? DATA_REGPC_INIT : '0;
      end
    end else if (s2Write && (cIdxReg <= LAST_IDX)) begin
      rf[cIdxReg] <= aluRes;
    end
  end

  // Stage-1 operand latch feeding stage 2
  always_ff @(posedge clk) begin
    if (!rstN) begin
      s2ValidReg <= 1'b0;
      opAReg     <= '0;
      opBReg     <= '0;
      cIdxReg    <= '0;
      aluOpReg   <= '0;
      cWriteReg  <= 1'b0;
    end else begin
      s2ValidReg <= accept;
      if (accept) begin
        opAReg    <= opANext;
        opBReg    <= opBNext;
        cIdxReg   <= cIdx;
        aluOpReg  <= alu_op;
        cWriteReg <= c_write_InHigh;
      end
    end
  end

  // PSR capture when a condition-code operation completes stage 2
  always_ff @(posedge clk) begin
    if (!rstN) begin
      psrReg <= '0;
    end else if (s2ValidReg && isCcOp(aluOpReg)) begin
      psrReg <= '{n: aluN, z: aluZ, v: aluV, c: aluC};
    end
  end

  assign result_valid_OutHigh = s2ValidReg;
  assign result_data          = s2ValidReg ? aluRes : '0;
  assign psr_n                = psrReg.n;
  assign psr_z                = psrReg.z;
  assign psr_v                = psrReg.v;
  assign psr_c                = psrReg.c;

endmodule

// File: tb/tb_udatapath_pipe.sv
// tb_udatapath_pipe: table-driven vectors plus hand sequences for the
// hazard, IR-select and reset corner cases. Results are matched through a
// scoreboard queue; the PSR is checked every cycle against committed flags.
module tb_udatapath_pipe;
  import udatapath_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [5:0]  mirA = '0, mirB = '0, mirC = '0;
  logic        selA = 1'b0, selB = 1'b0, selC = 1'b0;
  logic [3:0]  aluOp = '0;
  logic        cWrite = 1'b0;
  logic        resValid;
  logic [31:0] resData;
  logic        pN, pZ, pV, pC;
  logic [1:0]  irOp;
  logic [4:0]  irRd, irRs1, irRs2;
  logic [2:0]  irOp2;
  logic [5:0]  irOp3;
  logic        irBit13;

  udatapath_pipe dut (
    .udatapath_pipe_CLOCK_50    (clk),
    .udatapath_pipe_Reset_InLow (rstN),
    .uinst_valid_InHigh         (valid),
    .uinst_ready_OutHigh        (ready),
    .mir_a                      (mirA),
    .mir_b                      (mirB),
    .mir_c                      (mirC),
    .mux_sel_a                  (selA),
    .mux_sel_b                  (selB),
    .mux_sel_c                  (selC),
    .alu_op                     (aluOp),
    .c_write_InHigh             (cWrite),
    .result_valid_OutHigh       (resValid),
    .result_data                (resData),
    .psr_n                      (pN),
    .psr_z                      (pZ),
    .psr_v                      (pV),
    .psr_c                      (pC),
    .ir_op                      (irOp),
    .ir_rd                      (irRd),
    .ir_op2                     (irOp2),
    .ir_op3                     (irOp3),
    .ir_rs1                     (irRs1),
    .ir_bit13                   (irBit13),
    .ir_rs2                     (irRs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [5:0]  c;
    logic        cw;
    logic [31:0] data;
    logic [3:0]  nzvc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  psrAfter;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   resCount = 0;
  logic [3:0] psrModel = '0;
  logic [3:0] psrCommitted = '0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Issue one microinstruction (called at a negedge); returns stall cycles seen
  task automatic issue(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] c, input logic cw, input logic sa, input logic sb,
                       input logic sc, input logic [31:0] expData, input logic [3:0] expNzvc,
                       output int stalls);
    sb_t e;
    stalls = 0;
    aluOp = op; mirA = a; mirB = b; mirC = c; cWrite = cw;
    selA = sa; selB = sb; selC = sc; valid = 1'b1;
    #1;
    while (!ready && stalls < 4) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!ready) begin
      check("ready timeout", {31'b0, ready}, 32'd1);
      @(negedge clk);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      if (op[3:2] == 2'b00) psrModel = expNzvc;
      e.data = expData;
      e.psrAfter = psrModel;
      sbQ.push_back(e);
      @(negedge clk);
      valid = 1'b0;
      selA = 1'b0; selB = 1'b0; selC = 1'b0;
    end
  endtask

  // Result monitor: PSR against committed flags, results against the scoreboard
  initial begin
    forever begin
      sb_t e;
      @(negedge clk);
      if (checkEn) begin
        check("psr nzvc", {28'b0, pN, pZ, pV, pC}, {28'b0, psrCommitted});
        if (resValid) begin
          resCount++;
          if (sbQ.size() == 0) begin
            check("unexpected result", resData, 32'hDEAD_BEEF);
          end else begin
            e = sbQ.pop_front();
            $display("result %0d: data=%h expected=%h", resCount, resData, e.data);
            check("result_data", resData, e.data);
            psrCommitted = e.psrAfter;
          end
        end
      end
    end
  end

  initial begin
    int st;
    int expStall;

    // Operand registers: r0=0, r32=PC=0x800 after reset
    vecs.push_back('{ALU_ADD,      0, 32,  1, 1, 32'h0000_0800, 4'h0});
    vecs.push_back('{ALU_INC,      0,  0,  2, 1, 32'h0000_0001, 4'h0});
    vecs.push_back('{ALU_NOR,      0,  0,  6, 1, 32'hFFFF_FFFF, 4'h0});
    vecs.push_back('{ALU_SRL,      6,  2,  1, 1, 32'h7FFF_FFFF, 4'h0});
    vecs.push_back('{ALU_ADDCC,    1,  2,  3, 1, 32'h8000_0000, 4'b1010});
    vecs.push_back('{ALU_ADD,      1,  2,  7, 1, 32'h8000_0000, 4'h0});
    vecs.push_back('{ALU_ADD,     32,  0,  3, 0, 32'h0000_0800, 4'h0});
    vecs.push_back('{ALU_ANDCC,    6,  0,  8, 1, 32'h0000_0000, 4'b0100});
    vecs.push_back('{ALU_ADDCC,    6,  2,  9, 1, 32'h0000_0000, 4'b0101});
    vecs.push_back('{ALU_ORCC,     3,  2, 10, 1, 32'h8000_0001, 4'b1000});
    vecs.push_back('{ALU_NORCC,    6,  6, 11, 1, 32'h0000_0000, 4'b0100});
    vecs.push_back('{ALU_LSHIFT2, 32,  0, 12, 1, 32'h0000_2000, 4'h0});
    vecs.push_back('{ALU_LSHIFT10, 2,  0, 13, 1, 32'h0000_0400, 4'h0});
    vecs.push_back('{ALU_SIMM13,   6,  0, 14, 1, 32'h0000_1FFF, 4'h0});
    vecs.push_back('{ALU_LSHIFT2, 13,  0, 15, 1, 32'h0000_1000, 4'h0});
    vecs.push_back('{ALU_SEXT13,  15,  0, 16, 1, 32'hFFFF_F000, 4'h0});
    vecs.push_back('{ALU_INCPC,   32,  0, 17, 1, 32'h0000_0804, 4'h0});
    vecs.push_back('{ALU_RSHIFT5,  3,  0, 18, 1, 32'hFC00_0000, 4'h0});
    vecs.push_back('{ALU_OR,      12, 13, 19, 1, 32'h0000_2400, 4'h0});
    vecs.push_back('{ALU_AND,      6, 12, 20, 1, 32'h0000_2000, 4'h0});
    vecs.push_back('{ALU_SRL,      6, 13, 21, 1, 32'hFFFF_FFFF, 4'h0});
    vecs.push_back('{ALU_NOR,      2,  0, 22, 1, 32'hFFFF_FFFE, 4'h0});
    vecs.push_back('{ALU_NOR,      0,  0,  0, 1, 32'hFFFF_FFFF, 4'h0});
    vecs.push_back('{ALU_ADD,      0,  0, 23, 1, 32'h0000_0000, 4'h0});
    vecs.push_back('{ALU_SIMM13,  16,  0, 24, 1, 32'h0000_1000, 4'h0});
    // Build 0x8A004002 and write it into the IR (r37)
    vecs.push_back('{ALU_INCPC,    0,  0, 24, 1, 32'h0000_0004, 4'h0});
    vecs.push_back('{ALU_SRL,     32, 24, 25, 1, 32'h0000_0080, 4'h0});
    vecs.push_back('{ALU_INC,      2,  0, 26, 1, 32'h0000_0002, 4'h0});
    vecs.push_back('{ALU_ADD,     24, 24, 27, 1, 32'h0000_0008, 4'h0});
    vecs.push_back('{ALU_OR,      25, 27, 25, 1, 32'h0000_0088, 4'h0});
    vecs.push_back('{ALU_OR,      25, 26, 25, 1, 32'h0000_008A, 4'h0});
    vecs.push_back('{ALU_LSHIFT10,25,  0, 25, 1, 32'h0002_2800, 4'h0});
    vecs.push_back('{ALU_LSHIFT10,25,  0, 25, 1, 32'h08A0_0000, 4'h0});
    vecs.push_back('{ALU_LSHIFT2, 25,  0, 25, 1, 32'h2280_0000, 4'h0});
    vecs.push_back('{ALU_LSHIFT2, 25,  0, 25, 1, 32'h8A00_0000, 4'h0});
    vecs.push_back('{ALU_LSHIFT2, 15,  0, 28, 1, 32'h0000_4000, 4'h0});
    vecs.push_back('{ALU_OR,      28, 26, 28, 1, 32'h0000_4002, 4'h0});
    vecs.push_back('{ALU_OR,      25, 28, 37, 1, 32'h8A00_4002, 4'h0});

    // Reset held for two clocks
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result_valid", {31'b0, resValid}, 32'd0);
    check("reset result_data", resData, 32'd0);
    check("reset ready", {31'b0, ready}, 32'd1);
    check("reset psr", {28'b0, pN, pZ, pV, pC}, 32'd0);
    check("reset ir_op", {30'b0, irOp}, 32'd0);
    check("reset ir_rd", {27'b0, irRd}, 32'd0);
    rstN = 1'b1;
    checkEn = 1'b1;

    // Table vectors, back to back
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cw, 1'b0, 1'b0, 1'b0,
            vecs[i].data, vecs[i].nzvc, st);
    end

    // IR hazard: rs1 select right after the IR write stalls once; rs1=1 -> r1
    issue(ALU_ADD, 6'd0, 6'd0, 6'd29, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'h0, st);
    check("ir hazard stall", st, 32'd1);
    check("ir_op", {30'b0, irOp}, 32'd2);
    check("ir_rd", {27'b0, irRd}, 32'd5);
    check("ir_op2", {29'b0, irOp2}, 32'd0);
    check("ir_op3", {26'b0, irOp3}, 32'd0);
    check("ir_rs1", {27'b0, irRs1}, 32'd1);
    check("ir_bit13", {31'b0, irBit13}, 32'd0);
    check("ir_rs2", {27'b0, irRs2}, 32'd2);
    // rd select writes r5, rs2 select reads r2, then read r5 back
    issue(ALU_ADD, 6'd13, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 4'h0, st);
    issue(ALU_ADD, 6'd0, 6'd0, 6'd31, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 4'h0, st);
    issue(ALU_ADD, 6'd5, 6'd0, 6'd29, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 4'h0, st);

    // Back-to-back dependent ADDs
`ifdef UDATAPATH_FWD_EN
    expStall = 0;
`else
    expStall = 1;
`endif
    issue(ALU_ADD, 6'd13, 6'd12, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2400, 4'h0, st);
    issue(ALU_ADD, 6'd3, 6'd3, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4800, 4'h0, st);
    check("data hazard bubbles", st, expStall);

    // Reset while stage 2 holds ADD -> r5 = 7
    issue(ALU_OR, 6'd24, 6'd26, 6'd30, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0006, 4'h0, st);
    issue(ALU_ADD, 6'd30, 6'd2, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 4'h0, st);
    rstN = 1'b0;
    @(posedge clk);
    psrModel = '0;
    psrCommitted = '0;
    @(negedge clk);
    check("valid after mid-op reset", {31'b0, resValid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("ready after reset", {31'b0, ready}, 32'd1);
    check("ir_op after reset", {30'b0, irOp}, 32'd0);
    issue(ALU_ADD, 6'd5, 6'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, st);
    issue(ALU_ADD, 6'd0, 6'd32, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 4'h0, st);
    issue(ALU_ADD, 6'd37, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, st);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
